bit_serial_addsub_ctrl: RTL and testbench
=========================================

Name: bit_serial_addsub_ctrl

Overview:
- Sequences a single one-bit full-add datapath over WIDTH cycles to perform WIDTH-bit add or subtract, LSB first.
- Trades throughput for area in the ALU: one sum/carry cell plus shift registers and a carry flop, instead of a WIDTH-bit ripple chain.
- Uses a start/busy/done handshake toward the ALU top-level sequencer.

Parameters:
- WIDTH, 8: operand and result width in bits; legal values are 2..32.

Ports:
- clk, input, 1: single clock; rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request pulse or level; sampled only in IDLE or DONE.
- op, input, 1: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a, input, WIDTH: operand A; sampled with start.
- b, input, WIDTH: operand B; sampled with start.
- busy, output, 1: high while bit steps are in progress (RUN).
- done, output, 1: one-cycle pulse; result, cout and overflow are valid from this cycle on.
- result, output, WIDTH: sum or difference; held until the next completion.
- cout, output, 1: carry out of the MSB. For subtract, 1 means no borrow.
- overflow, output, 1: two's-complement signed overflow.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0; shift regs, carry flop and counter all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge t0:
  - Load opA<=a and opB<=(op ? ~b : b).
  - Load carry<=op and cnt<=0.
  - Go to RUN.
- RUN, each edge (one bit step):
  - s=opA[0]^opB[0]^carry.
  - carry<=(opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - Shift s into a sum register from the MSB end; shift opA and opB right by 1; cnt++.
  - Before the final step (cnt==WIDTH-1), capture the carry-in to the MSB as cmsb.
- RUN exit: the step with cnt==WIDTH-1 occurs at edge t0+WIDTH and transitions to DONE. On that edge:
  - result<=final sum.
  - cout<=final carry.
  - overflow<=cmsb ^ final carry.
- Latency: done is high in the cycle following edge t0+WIDTH, i.e. WIDTH+1 cycles after start is sampled. busy=1 exactly for the WIDTH cycles in RUN.
- DONE: done=1 for one cycle.
  - If start=1, the new request is accepted as from IDLE: back-to-back with no idle bubble, next done WIDTH+1 cycles later.
  - Otherwise go to IDLE.
- start while in RUN: ignored; operands are not re-sampled.
- Output stability: result, cout and overflow change only on the RUN->DONE edge (or reset). They hold their values through IDLE and through subsequent RUN.
- Wrap-around: the sum is modulo 2^WIDTH. cout and overflow carry the out-of-range information.
- Reset mid-RUN: the operation is discarded, no done pulse is issued, outputs return to 0.

Optional Feature:
- Macro: BSA_ABORT_EN.
- With the macro defined:
  - Extra input port abort (1 bit) is present.
  - abort=1 in RUN: go to IDLE at the next edge; no done pulse; result, cout and overflow keep their previous values.
  - abort in IDLE or DONE: no effect.
  - abort and start together in DONE: start wins.
- Without the macro: no abort port; RUN always runs to completion.

Decomposition:
- Shared package bsa_pkg:
  - State encoding: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Op encoding: OP_ADD=1'b0, OP_SUB=1'b1.
  - Counter-width function clog2-based: ceil(log2(WIDTH)).
- One sub-module, bsa_datapath:
  - Contents: the operand shift registers, sum shift register, one-bit sum/carry logic, carry flop and cmsb capture.
  - Controlled by load/step strobes from the FSM in bit_serial_addsub_ctrl.

Test Plan (WIDTH=8):
- Add: a=8'h35, b=8'h4A, op=0 -> result=8'h7F, cout=0, overflow=0; busy high 8 cycles; done exactly 9 cycles after start.
- Unsigned wrap: a=8'hFF, b=8'h01, op=0 -> result=8'h00, cout=1, overflow=0.
- Signed overflow:
  - a=8'h7F, b=8'h01, op=0 -> result=8'h80, cout=0, overflow=1.
  - a=8'h80, b=8'h01, op=1 -> result=8'h7F, cout=1, overflow=1.
- Handshake:
  - start held high through RUN with new operands -> ignored; first result unchanged.
  - start high in the DONE cycle with a=8'h10, b=8'h03, op=1 -> accepted; result=8'h0D on the next done, 9 cycles later.
- Reset mid-op: rst pulsed at cnt=4 of a RUN -> busy, done, result, cout and overflow are 0 immediately, asynchronously; state IDLE; no done afterwards.
- Abort (BSA_ABORT_EN): complete 8'h35+8'h4A, then start 8'h01+8'h01 and assert abort at cnt=3 -> no done pulse; result stays 8'h7F; next start completes normally.

Source files
------------

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial add/subtract controller and its datapath.
package bsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit-step counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bsa_datapath.sv
// One-bit full-add cell with operand/sum shift registers and carry flop, LSB first.
module bsa_datapath
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_next,
    output logic             carry_next,
    output logic             cmsb
);

    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             s;

    assign s          = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_next = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
    assign sum_next   = {s, sum_q[WIDTH-1:1]};
    // During the final step the carry flop holds the carry into the MSB.
    assign cmsb       = carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            opa_q   <= a;
            opb_q   <= (op == OP_SUB) ? ~b : b;
            sum_q   <= '0;
            carry_q <= (op == OP_ADD) ? 1'b0 : 1'b1;
        end else if (step) begin
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            sum_q   <= sum_next;
            carry_q <= carry_next;
        end
    end

endmodule

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer with start/busy/done handshake.
// Define BSA_ABORT_EN to add an abort input that cancels a running operation.
module bit_serial_addsub_ctrl
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef BSA_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             load, step, last;
    logic             abort_run;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;
    logic             cmsb;

`ifdef BSA_ABORT_EN
    assign abort_run = abort;
`else
    assign abort_run = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_run) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        last    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Back-to-back request: accept without an idle bubble.
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (last) begin
                result   <= sum_next;
                cout     <= carry_next;
                overflow <= cmsb ^ carry_next;
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    bsa_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .op         (op),
        .a          (a),
        .b          (b),
        .sum_next   (sum_next),
        .carry_next (carry_next),
        .cmsb       (cmsb)
    );

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Self-checking bench for bit_serial_addsub_ctrl (WIDTH=8): vector table, handshake
// sequences and randomized operations against an arithmetic reference model.
module tb_bit_serial_addsub_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef BSA_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bit_serial_addsub_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
`ifdef BSA_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mop, output logic [W-1:0] r,
                                  output logic c, output logic v);
        int ua, ub, full, sa, sb, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (mop) begin
            full = ua - ub;
            c    = (ua >= ub);
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full > 255);
            sr   = sa + sb;
        end
        r = full[W-1:0];
        v = (sr > 127) || (sr < -128);
    endfunction

    // Step until done is seen; lat = edges after the accepting edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic top,
                          output int lat, output int bcnt);
        start = 1'b1;
        a     = ta;
        b     = tb;
        op    = top;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        wait_done(lat, bcnt);
    endtask

    vec_t         tbl[7];
    int           lat, bcnt;
    logic [W-1:0] er;
    logic         ec, ev;
    logic [W-1:0] ra, rb;
    logic         rop;
    int           seen;

    initial begin
        tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h10, 8'h03, 1'b1, 8'h0D, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
`ifdef BSA_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].op, lat, bcnt);
            chk($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W));
            chk($sformatf("tbl%0d_busy_cycles", i), 32'(bcnt), 32'(W));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("tbl%0d_hold", i), 32'(result), 32'(tbl[i].r));
        end

        // start held through RUN with new operands, then accepted in the DONE cycle.
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h4A;
        op    = 1'b0;
        @(posedge clk);
        #1;
        a  = 8'h10;
        b  = 8'h03;
        op = 1'b1;
        wait_done(lat, bcnt);
        chk("held_start_result", 32'(result), 32'h7F);
        chk("held_start_latency", 32'(lat), 32'(W));
        @(posedge clk);
        #1;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_result_held", 32'(result), 32'h7F);
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_result", 32'(result), 32'h0D);
        chk("b2b_cout", 32'(cout), 32'd1);
        chk("b2b_latency", 32'(lat + 1), 32'(W + 1));
        @(posedge clk);
        #1;

        // Asynchronous reset at cnt=4.
        start = 1'b1;
        a     = 8'h7F;
        b     = 8'h01;
        op    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("midrst_no_activity", 32'(seen), 32'd0);

`ifdef BSA_ABORT_EN
        run_op(8'h35, 8'h4A, 1'b0, lat, bcnt);
        chk("abort_pre_result", 32'(result), 32'h7F);
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        op    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        seen  = 0;
        repeat (W + 3) begin
            if (done || busy) seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_result_kept", 32'(result), 32'h7F);
        run_op(8'h01, 8'h01, 1'b0, lat, bcnt);
        chk("abort_after_result", 32'(result), 32'h02);
        @(posedge clk);
        #1;
`endif

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rop = 1'($urandom);
            model(ra, rb, rop, er, ec, ev);
            run_op(ra, rb, rop, lat, bcnt);
            chk($sformatf("rnd%0d_result", i), 32'(result), 32'(er));
            chk($sformatf("rnd%0d_cout", i), 32'(cout), 32'(ec));
            chk($sformatf("rnd%0d_ovf", i), 32'(overflow), 32'(ev));
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
